// File: rtl/riscv_pkg.sv
// Shared RV32I control types: ALU operations, multicycle FSM states,
// opcode constants and datapath mux-select encodings.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_ops_t;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } mc_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 decode to an ALU operation plus a legality flag;
// shared between the multicycle and single-cycle cores.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output alu_ops_t   alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct3)
      3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_ctrl = ALU_AND;
      3'b110:  alu_ctrl = ALU_OR;
      3'b100:  alu_ctrl = ALU_XOR;
      3'b010:  alu_ctrl = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: drives ALU op, datapath selects and write
// enables one step per state, with a memory handshake and retired count.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output alu_ops_t             alu_ctrl,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic                 adr_src,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret
);

  mc_state_t state, state_nxt;
  alu_ops_t  dec_alu;
  logic      dec_legal;
  logic      funct_bad;
  logic      retire;

  alu_decoder u_alu_dec (
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .is_rtype (state == S_EXECR),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Remembers a bad funct3 from EXEC so the following ALUWB neither writes nor retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      funct_bad <= 1'b0;
    else if (state == S_EXECR || state == S_EXECI)   funct_bad <= !dec_legal;
    else if (state == S_DECODE)                      funct_bad <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_nxt     = state;
    alu_ctrl      = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALUOUT;
    imm_src       = IMM_I;
    adr_src       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    retire        = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          pc_write   = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed here speculatively into alu_out.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BEQ;
          OP_JAL:            state_nxt = S_JAL;
          default: begin
            illegal_instr = 1'b1;
            state_nxt     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        alu_ctrl      = dec_alu;
        illegal_instr = !dec_legal;
        state_nxt     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_IMM;
        imm_src       = IMM_I;
        alu_ctrl      = dec_alu;
        illegal_instr = !dec_legal;
        state_nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = !funct_bad;
        retire    = !funct_bad;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_ctrl  = ALU_SUB;
        if (funct3 == 3'b000) begin
          pc_write = zero;
          retire   = 1'b1;
        end else begin
          illegal_instr = 1'b1;
        end
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction step-plan model
// predicts every cycle's outputs, plus a few hand-computed literal checks.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5, zero, mem_ready;
  alu_ops_t    alu_ctrl;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic        adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, illegal_instr;
  logic [31:0] instret;

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .illegal_instr(illegal_instr), .instret(instret)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, fetches = 0, seen = 0;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] sa, sb, res, imm;
    logic adr, req, we, irw, pcw, regw, ill;
  } exp_t;

  // One step of an instruction's plan; wait steps hold until mem_ready.
  typedef struct {
    exp_t wait_o;
    exp_t done_o;
    bit   wait_mem;
    bit   pcw_zero;
    bit   retire;
    bit   is_fetch;
    bit   is_decode;
  } step_t;

  typedef struct { logic [6:0] op; logic [2:0] f3; logic f7; } instr_t;

  step_t       plan[$];
  instr_t      dq[$];
  logic [31:0] model_cnt;

  function automatic step_t mk(input exp_t o);
    step_t s;
    s.wait_o = o; s.done_o = o; s.wait_mem = 0; s.pcw_zero = 0;
    s.retire = 0; s.is_fetch = 0; s.is_decode = 0;
    return s;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7,
                                         input bit rtype, output bit legal);
    legal = 1;
    case (f3)
      3'b000:  return (rtype && f7) ? 3'(ALU_SUB) : 3'(ALU_ADD);
      3'b111:  return 3'(ALU_AND);
      3'b110:  return 3'(ALU_OR);
      3'b100:  return 3'(ALU_XOR);
      3'b010:  return 3'(ALU_SLT);
      default: begin legal = 0; return 3'(ALU_ADD); end
    endcase
  endfunction

  function automatic bit known_op(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
  endfunction

  function automatic step_t fetch_step();
    exp_t w = '0, d = '0;
    step_t s;
    w.req = 1;
    d.req = 1; d.irw = 1; d.sb = 2'b10; d.res = 2'b10; d.pcw = 1;
    s = mk(d); s.wait_o = w; s.wait_mem = 1; s.is_fetch = 1;
    return s;
  endfunction

  function automatic step_t decode_step();
    exp_t d = '0;
    step_t s;
    d.sa = 2'b01; d.sb = 2'b01; d.imm = 2'b10;
    s = mk(d); s.is_decode = 1;
    return s;
  endfunction

  // Remaining steps of an instruction after decode, from its fields.
  function automatic void build_rest(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    exp_t o; step_t s; bit lg;
    case (op)
      OP_LOAD, OP_STORE: begin
        o = '0; o.sa = 2'b10; o.sb = 2'b01; o.imm = (op == OP_STORE) ? 2'b01 : 2'b00;
        plan.push_back(mk(o));
        o = '0; o.req = 1; o.adr = 1; o.we = (op == OP_STORE);
        s = mk(o); s.wait_mem = 1; s.retire = (op == OP_STORE);
        plan.push_back(s);
        if (op == OP_LOAD) begin
          o = '0; o.res = 2'b01; o.regw = 1;
          s = mk(o); s.retire = 1; plan.push_back(s);
        end
      end
      OP_RTYPE, OP_ITYPE: begin
        o = '0; o.sa = 2'b10; o.sb = (op == OP_ITYPE) ? 2'b01 : 2'b00;
        o.alu = ref_alu(f3, f7, op == OP_RTYPE, lg); o.ill = !lg;
        plan.push_back(mk(o));
        o = '0; o.regw = lg;
        s = mk(o); s.retire = lg; plan.push_back(s);
      end
      OP_BRANCH: begin
        o = '0; o.sa = 2'b10; o.alu = 3'(ALU_SUB); o.ill = (f3 != 3'b000);
        s = mk(o); s.pcw_zero = (f3 == 3'b000); s.retire = (f3 == 3'b000);
        plan.push_back(s);
      end
      OP_JAL: begin
        o = '0; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1;
        plan.push_back(mk(o));
        o = '0; o.regw = 1;
        s = mk(o); s.retire = 1; plan.push_back(s);
      end
      default: ;
    endcase
  endfunction

  task automatic chk_out(input exp_t act, input exp_t expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL outputs cyc=%0d act=%h exp=%h (alu,sa,sb,res,imm,adr,req,we,irw,pcw,regw,ill)",
               cyc, act, expv);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, expv);
    end
  endtask

  // Compare process: advances the model one cycle and checks every output.
  always @(negedge clk) begin
    exp_t  e, a;
    step_t s;
    bit    popped;
    cyc++;
    popped = 0;
    a = '{alu: alu_ctrl, sa: alu_src_a, sb: alu_src_b, res: result_src, imm: imm_src,
          adr: adr_src, req: mem_req, we: mem_we, irw: ir_write, pcw: pc_write,
          regw: reg_write, ill: illegal_instr};
    if (!rst_n) begin
      plan.delete();
      plan.push_back(mk('0));
      model_cnt = 0;
      chk_out(a, '0);
      lit("reset instret", instret, 0);
    end else begin
      if (plan.size() == 0) plan.push_back(fetch_step());
      s = plan[0];
      if (s.wait_mem && !mem_ready) e = s.wait_o;
      else begin
        e = s.done_o;
        if (s.is_decode) e.ill = !known_op(opcode);
        if (s.pcw_zero) e.pcw = zero;
        void'(plan.pop_front());
        popped = 1;
        if (s.is_fetch) begin fetches++; plan.push_back(decode_step()); end
        if (s.is_decode) build_rest(opcode, funct3, funct7b5);
      end
      chk_out(a, e);
      lit("instret", instret, model_cnt);
      if (popped && s.retire) model_cnt++;
    end
  end

  task automatic pick(output instr_t t);
    int r = $urandom_range(0, 13);
    t.f3 = 3'($urandom_range(0, 7));
    t.f7 = 1'($urandom_range(0, 1));
    case (r)
      0, 1:     t.op = OP_LOAD;
      2, 3:     t.op = OP_STORE;
      4, 5, 6:  t.op = OP_RTYPE;
      7, 8:     t.op = OP_ITYPE;
      9, 10: begin
        t.op = OP_BRANCH;
        if ($urandom_range(0, 9) < 7) t.f3 = 3'b000;
      end
      11:       t.op = OP_JAL;
      12:       t.op = 7'($urandom);
      default:  t.op = OP_RTYPE;
    endcase
  endtask

  // Present the fetched instruction on the IR fields once ir_write has fired.
  task automatic drive(input bit rnd_ready);
    instr_t t;
    if (fetches != seen) begin
      seen = fetches;
      if (dq.size() > 0) t = dq.pop_front();
      else pick(t);
      opcode = t.op; funct3 = t.f3; funct7b5 = t.f7;
    end
    if (rnd_ready) mem_ready = ($urandom_range(0, 3) != 0);
    zero = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bit hit;
    opcode = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    dq.push_back('{op: OP_RTYPE, f3: 3'b000, f7: 1'b0});  // add
    dq.push_back('{op: OP_RTYPE, f3: 3'b000, f7: 1'b1});  // sub
    dq.push_back('{op: OP_ITYPE, f3: 3'b000, f7: 1'b1});  // addi, instr[30]=1
    dq.push_back('{op: 7'h7F,    f3: 3'b000, f7: 1'b0});  // illegal opcode
    dq.push_back('{op: OP_RTYPE, f3: 3'b001, f7: 1'b0});  // unsupported funct3
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 1500; k++) begin
      @(negedge clk); #1;
      case (k)
        0:  lit("idle req/irw", {30'd0, mem_req, ir_write}, 0);
        1:  lit("fetch req/irw/pcw", {29'd0, mem_req, ir_write, pc_write}, 32'h7);
        2:  lit("decode src_a", {30'd0, alu_src_a}, 32'h1);
        3:  lit("add execr alu", {29'd0, alu_ctrl}, {29'd0, ALU_ADD});
        4:  lit("add aluwb regw", {31'd0, reg_write}, 1);
        5:  lit("add instret", instret, 1);
        7:  lit("sub execr alu", {29'd0, alu_ctrl}, {29'd0, ALU_SUB});
        11: lit("addi execi alu", {29'd0, alu_ctrl}, {29'd0, ALU_ADD});
        14: lit("illegal opcode pulse", {31'd0, illegal_instr}, 1);
        17: lit("bad funct3 pulse", {31'd0, illegal_instr}, 1);
        18: lit("bad funct3 no regw", {31'd0, reg_write}, 0);
        19: lit("instret after illegals", instret, 3);
        default: ;
      endcase
      @(posedge clk); #1;
      drive(k >= 20);
    end

    // Abort a store mid-access with an asynchronous reset.
    dq.push_back('{op: OP_STORE, f3: 3'b010, f7: 1'b0});
    hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we) hit = 1;
      else begin @(posedge clk); #1; drive(1); end
    end
    lit("store reached before timeout", {31'd0, hit}, 1);
    rst_n = 1'b0;
    #1;
    lit("async reset req/we", {30'd0, mem_req, mem_we}, 0);
    lit("async reset instret", instret, 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    lit("idle after reset", {31'd0, mem_req}, 0);
    @(posedge clk); #1; drive(0);
    @(negedge clk); #1;
    lit("fetch after reset", {31'd0, mem_req}, 1);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      drive(1);
    end
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
